// File: rtl/uart_cmd_link.sv
// UART command link: 8N1 receiver that packs three bytes into a 24-bit command,
// plus an 8N1 transmitter for single response bytes.
module uart_cmd_link #(
   parameter int unsigned BAUD_DIV     = 434,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp_data,
   input  logic        send_resp,
   output logic        resp_sent
);

   localparam int unsigned BW   = $clog2(BAUD_DIV);
   localparam int unsigned TOUT = TIMEOUT_BITS * BAUD_DIV;
   localparam int unsigned TW   = $clog2(TOUT + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
   localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT - 1);
   localparam logic [TW-1:0] TOUT_MAX  = TW'(TOUT);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   rx_state_t       rx_state;
   tx_state_t       tx_state;
   logic            rx_meta;
   logic            rx_s;
   logic [BW-1:0]   rx_cnt;
   logic [3:0]      rx_bit;
   logic [7:0]      rx_shift;
   logic [1:0]      byte_cnt;
   logic [TW-1:0]   tmo;
   logic [BW-1:0]   tx_cnt;
   logic [3:0]      tx_bit;
   logic [7:0]      tx_shift;

   // Two-flop synchronizer for the asynchronous RX pin
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // Receiver, command aggregator and partial-command timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         byte_cnt <= '0;
         tmo      <= '0;
         cmd      <= '0;
         cmd_rdy  <= 1'b0;
      end else begin
         if (clr_cmd_rdy)
            cmd_rdy <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (tmo != TOUT_MAX)
                  tmo <= tmo + TW'(1);
               if (byte_cnt != 2'd0 && tmo >= TOUT_LAST)
                  byte_cnt <= 2'd0;
               if (!rx_s) begin
                  rx_state <= RX_START;
                  tmo      <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == BAUD_HALF) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  if (rx_bit == 4'd7)
                     rx_state <= RX_STOP;
                  else
                     rx_bit <= rx_bit + 4'd1;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt <= '0;
                  if (rx_s) begin
                     rx_state <= RX_IDLE;
                     // A byte arriving while a command is pending is an overrun and is dropped
                     if (!cmd_rdy) begin
                        case (byte_cnt)
                           2'd0:    cmd[23:16] <= rx_shift;
                           2'd1:    cmd[15:8]  <= rx_shift;
                           default: cmd[7:0]   <= rx_shift;
                        endcase
                        if (byte_cnt == 2'd2) begin
                           byte_cnt <= 2'd0;
                           cmd_rdy  <= 1'b1;
                        end else begin
                           byte_cnt <= byte_cnt + 2'd1;
                        end
                     end
                  end else begin
                     byte_cnt <= 2'd0;
                     rx_state <= RX_BREAK;
                  end
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RX_BREAK: begin
               // Hold off until the line returns high so a break is not seen as new starts
               if (rx_s)
                  rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Response transmitter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         TX        <= 1'b1;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx_cnt <= '0;
               tx_bit <= '0;
               TX     <= 1'b1;
               if (send_resp) begin
                  tx_shift <= resp_data;
                  TX       <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt   <= '0;
                  TX       <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + BW'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd7) begin
                     TX       <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 4'd1;
                     TX       <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + BW'(1);
               end
            end
            TX_STOP: begin
               // Registered pulse lands in the final clock of the stop bit
               if (tx_cnt == BAUD_PRE)
                  resp_sent <= 1'b1;
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + BW'(1);
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: directed scenarios plus randomized byte streams checked
// against a byte-level command model and expected serial frames.
module tb_uart_cmd_link;

   localparam int B     = 8;
   localparam int TBITS = 4;
   localparam int LIMIT = TBITS * B;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RX;
   logic        TX;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp_data;
   logic        send_resp;
   logic        resp_sent;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_end = 0;

   // Byte-level model of the command register
   logic [23:0] m_cmd;
   logic        m_rdy;
   int          m_cnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_cmd_link #(.BAUD_DIV(B), .TIMEOUT_BITS(TBITS)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
      .resp_sent(resp_sent)
   );

   task automatic model_reset();
      m_cmd = 24'h0;
      m_rdy = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok);
      if (!ok) m_cnt = 0;
      else if (!m_rdy) begin
         m_cmd[8*(2-m_cnt) +: 8] = b;
         m_cnt = m_cnt + 1;
         if (m_cnt == 3) begin
            m_cnt = 0;
            m_rdy = 1'b1;
         end
      end
   endtask

   // Drive one 8N1 frame on RX; optionally pulse clr_cmd_rdy in the stop-sample clock
   task automatic rx_frame(input logic [7:0] b, input bit ok, input bit clr_stop);
      logic [9:0] fr;
      if (cyc - last_end >= LIMIT) m_cnt = 0;
      fr = {ok, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = fr[i];
         for (int j = 0; j < B; j++) begin
            @(negedge clk);
            if (i == 9 && clr_stop) clr_cmd_rdy = (j == B - 2);
         end
      end
      RX = 1'b1;
      model_byte(b, ok);
      if (clr_stop) m_rdy = 1'b0;
      last_end = cyc;
   endtask

   task automatic clear_rdy();
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      m_rdy = 1'b0;
   endtask

   // Offer d in the current cycle T and check TX/resp_sent over T+1..T+80
   task automatic test_tx_frame(input logic [7:0] d, input int busy_k);
      logic [9:0] fr;
      logic       exp_tx;
      fr = {1'b1, d, 1'b0};
      resp_data = d;
      send_resp = 1'b1;
      for (int k = 1; k <= 10 * B; k++) begin
         @(negedge clk);
         send_resp = (busy_k != 0 && k == busy_k);
         if (k == 1) resp_data = 8'($urandom);
         if (busy_k != 0 && k == busy_k) resp_data = 8'hEE;
         exp_tx = fr[(k - 1) / B];
         checks++;
         if (TX !== exp_tx) begin
            errors++;
            $display("FAIL tx_bit data=%h k=%0d: TX=%b expected %b", d, k, TX, exp_tx);
         end
         checks++;
         if (resp_sent !== (k == 10 * B)) begin
            errors++;
            $display("FAIL resp_sent data=%h k=%0d: got %b expected %b", d, k, resp_sent, (k == 10 * B));
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", TX); end
      checks++; if (cmd !== 24'h0) begin errors++; $display("FAIL reset_cmd: got %h expected 000000", cmd); end
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", cmd_rdy); end
      checks++; if (resp_sent !== 1'b0) begin errors++; $display("FAIL reset_sent: got %b expected 0", resp_sent); end
      rst_n = 1'b1;
      @(negedge clk);
      last_end = cyc;
   endtask

   task automatic test_cmd_assembly();
      rx_frame(8'h02, 1'b1, 1'b0);
      rx_frame(8'h05, 1'b1, 1'b0);
      rx_frame(8'h1C, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h02051C) begin errors++; $display("FAIL assembly_cmd: got %h expected 02051c", cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL assembly_rdy: got %b expected 1", cmd_rdy); end
      clear_rdy();
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clear_rdy: got %b expected 0", cmd_rdy); end
      checks++; if (cmd !== 24'h02051C) begin errors++; $display("FAIL clear_cmd_kept: got %h expected 02051c", cmd); end
   endtask

   task automatic test_tx_response();
      test_tx_frame(8'hA5, 0);
      @(negedge clk);
      checks++; if (TX !== 1'b1 || resp_sent !== 1'b0) begin errors++; $display("FAIL tx_gap: TX=%b sent=%b expected 1/0", TX, resp_sent); end
      test_tx_frame(8'($urandom), 0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         test_tx_frame(8'($urandom), 0);
      end
      @(negedge clk);
   endtask

   task automatic test_framing();
      rx_frame(8'h09, 1'b1, 1'b0);
      rx_frame(8'h33, 1'b0, 1'b0);
      repeat (16) @(negedge clk);
      rx_frame(8'h09, 1'b1, 1'b0);
      rx_frame(8'h12, 1'b1, 1'b0);
      rx_frame(8'hAB, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h0912AB) begin errors++; $display("FAIL framing_cmd: got %h expected 0912ab", cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL framing_rdy: got %b expected 1", cmd_rdy); end
      clear_rdy();
      RX = 1'b0;
      repeat (2) @(negedge clk);
      RX = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b expected 0", cmd_rdy); end
      for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== m_cmd) begin errors++; $display("FAIL glitch_cmd: got %h expected %h", cmd, m_cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL glitch_cmd_rdy: got %b expected 1", cmd_rdy); end
      clear_rdy();
   endtask

   task automatic test_timeout();
      rx_frame(8'h01, 1'b1, 1'b0);
      rx_frame(8'h02, 1'b1, 1'b0);
      repeat (40) @(negedge clk);
      rx_frame(8'h07, 1'b1, 1'b0);
      rx_frame(8'h00, 1'b1, 1'b0);
      rx_frame(8'h3F, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h07003F) begin errors++; $display("FAIL timeout_cmd: got %h expected 07003f", cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL timeout_rdy: got %b expected 1", cmd_rdy); end
   endtask

   task automatic test_overrun();
      rx_frame(8'h55, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h07003F) begin errors++; $display("FAIL overrun_cmd: got %h expected 07003f", cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL overrun_rdy: got %b expected 1", cmd_rdy); end
      // Clear coinciding with the stop sample of a byte: byte still dropped
      rx_frame(8'h66, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h07003F) begin errors++; $display("FAIL overrun_clr_cmd: got %h expected 07003f", cmd); end
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL overrun_clr_rdy: got %b expected 0", cmd_rdy); end
      rx_frame(8'h06, 1'b1, 1'b0);
      rx_frame(8'h15, 1'b1, 1'b0);
      rx_frame(8'h00, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== 24'h061500) begin errors++; $display("FAIL overrun_next_cmd: got %h expected 061500", cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL overrun_next_rdy: got %b expected 1", cmd_rdy); end
      clear_rdy();
   endtask

   task automatic test_busy();
      test_tx_frame(8'h3C, 30);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (TX !== 1'b1 || resp_sent !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle k=%0d: TX=%b sent=%b expected 1/0", k, TX, resp_sent);
         end
      end
   endtask

   task automatic test_concurrent();
      fork
         begin
            for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'b1, 1'b0);
         end
         test_tx_frame(8'($urandom), 0);
      join
      repeat (2) @(negedge clk);
      checks++; if (cmd !== m_cmd) begin errors++; $display("FAIL concurrent_cmd: got %h expected %h", cmd, m_cmd); end
      checks++; if (cmd_rdy !== m_rdy) begin errors++; $display("FAIL concurrent_rdy: got %b expected %b", cmd_rdy, m_rdy); end
      clear_rdy();
   endtask

   task automatic test_random();
      logic [7:0] b;
      bit         ok;
      int         gap;
      for (int n = 0; n < 24; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(7) != 0);
         rx_frame(b, ok, 1'b0);
         repeat (2) @(negedge clk);
         checks++; if (cmd !== m_cmd) begin errors++; $display("FAIL random_cmd n=%0d: got %h expected %h", n, cmd, m_cmd); end
         checks++; if (cmd_rdy !== m_rdy) begin errors++; $display("FAIL random_rdy n=%0d: got %b expected %b", n, cmd_rdy, m_rdy); end
         if (m_rdy && $urandom_range(3) != 0) clear_rdy();
         gap = ($urandom_range(3) == 0) ? int'($urandom_range(56, 40)) : int'($urandom_range(8));
         if (!ok && gap < 16) gap = 16;
         repeat (gap) @(negedge clk);
      end
      if (m_rdy) clear_rdy();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      resp_data = 8'h00;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      RX = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (TX !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b expected 0", TX); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL pre_reset_rdy: got %b expected 1", cmd_rdy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", TX); end
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL midreset_rdy: got %b expected 0", cmd_rdy); end
      checks++; if (cmd !== 24'h0) begin errors++; $display("FAIL midreset_cmd: got %h expected 000000", cmd); end
      @(negedge clk);
      RX = 1'b1;
      rst_n = 1'b1;
      model_reset();
      last_end = cyc;
      rx_frame(8'($urandom), 1'b1, 1'b0);
      RX = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      RX = 1'b1;
      rst_n = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      last_end = cyc;
      for (int i = 0; i < 3; i++) rx_frame(8'($urandom), 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (cmd !== m_cmd) begin errors++; $display("FAIL postreset_cmd: got %h expected %h", cmd, m_cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL postreset_rdy: got %b expected 1", cmd_rdy); end
   endtask

   initial begin
      rst_n       = 1'b0;
      RX          = 1'b1;
      clr_cmd_rdy = 1'b0;
      send_resp   = 1'b0;
      resp_data   = 8'h00;
      model_reset();
      test_reset();
      test_cmd_assembly();
      test_tx_response();
      test_framing();
      test_timeout();
      test_overrun();
      test_busy();
      test_concurrent();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
